// File: rtl/float8_pkg.sv
// Shared constants, types and arithmetic helpers for the FC-layer float8 MAC responder.
// Operands are sign-magnitude Q0.7; the result is sign-magnitude Q0.14 with saturation.
package float8_pkg;

   localparam int LANES   = 128;
   localparam int GROUP   = 16;
   localparam int NGROUP  = LANES / GROUP;
   localparam int GRP_W   = $clog2(NGROUP);
   localparam int ACC_W   = 22;
   localparam int PART_W  = 19;
   localparam int RES_W   = 15;
   localparam int MAG_MAX = 16383;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   typedef struct packed {
      logic             ovf;
      logic [RES_W-1:0] sm;
   } sat_res_t;

   // Sign-magnitude lane product as a signed 16-bit value; a -0 operand yields +0.
   function automatic logic signed [15:0] sm8_mul_s16(input logic [7:0] a, input logic [7:0] b);
      logic [13:0] mag;
      mag = 14'(a[6:0]) * 14'(b[6:0]);
      if (a[7] ^ b[7]) begin
         return -$signed({2'b00, mag});
      end
      return $signed({2'b00, mag});
   endfunction

   // Two's-complement accumulator to saturated sign-magnitude, never producing -0.
   function automatic sat_res_t s_to_sm15_sat(input logic signed [ACC_W-1:0] acc);
      sat_res_t         res;
      logic [ACC_W-1:0] mag;
      mag          = acc[ACC_W-1] ? -acc : acc;
      res.ovf      = (mag > ACC_W'(MAG_MAX));
      res.sm[13:0] = res.ovf ? 14'h3FFF : mag[13:0];
      res.sm[14]   = acc[ACC_W-1] && (res.sm[13:0] != 14'h0000);
      return res;
   endfunction

endpackage

// File: rtl/float8_dot16.sv
// Combinational 16-lane sign-magnitude multiply with a balanced adder tree.
// The tree grows one bit per level, so the 19-bit partial sum is exact.
module float8_dot16
   import float8_pkg::*;
(
   input  logic [GROUP*8-1:0]        a_i,
   input  logic [GROUP*8-1:0]        b_i,
   output logic signed [PART_W-1:0]  sum_o
);

   logic signed [15:0] prod [GROUP];
   logic signed [16:0] lvl1 [GROUP/2];
   logic signed [17:0] lvl2 [GROUP/4];
   logic signed [18:0] lvl3 [GROUP/8];

   // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < GROUP; i++) begin
         prod[i] = sm8_mul_s16(a_i[8*i +: 8], b_i[8*i +: 8]);
      end
      for (int i = 0; i < GROUP/2; i++) begin
         lvl1[i] = {prod[2*i][15], prod[2*i]} + {prod[2*i+1][15], prod[2*i+1]};
      end
      for (int i = 0; i < GROUP/4; i++) begin
         lvl2[i] = {lvl1[2*i][16], lvl1[2*i]} + {lvl1[2*i+1][16], lvl1[2*i+1]};
      end
      for (int i = 0; i < GROUP/8; i++) begin
         lvl3[i] = {lvl2[2*i][17], lvl2[2*i]} + {lvl2[2*i+1][17], lvl2[2*i+1]};
      end
      // Each half is bounded by 8*127*127, so the final add cannot leave 19 bits.
      sum_o = lvl3[0] + lvl3[1];
   end

endmodule

// File: rtl/float8_mac_responder.sv
// Responder for the FC-layer MAC interface: 128-lane dot product computed over
// eight cycles, one 16-lane group per cycle, behind a req/busy/valid handshake.
module float8_mac_responder
   import float8_pkg::*;
(
   input  logic                 clk,
   input  logic                 iRst_n,
   input  logic                 ena,
   input  logic                 req,
   input  logic [LANES*8-1:0]   opr1,
   input  logic [LANES*8-1:0]   opr2,
   output logic                 busy,
   output logic                 valid,
   output logic [RES_W-1:0]     result,
   output logic                 overflow
);

   logic [0:0]               state_q, state_d;
   logic [GRP_W-1:0]         grp_q, grp_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic                     busy_q, busy_d;
   logic                     valid_q, valid_d;
   logic                     ovf_q, ovf_d;
   logic [RES_W-1:0]         result_q, result_d;
   logic [LANES*8-1:0]       opa_q, opb_q;
   logic [GROUP*8-1:0]       slice_a, slice_b;
   logic signed [PART_W-1:0] partial;
   logic                     accept;
   sat_res_t                 sat;

   assign accept  = ena && (state_q == ST_IDLE) && req;
   assign slice_a = opa_q[grp_q*(GROUP*8) +: GROUP*8];
   assign slice_b = opb_q[grp_q*(GROUP*8) +: GROUP*8];

   float8_dot16 u_dot16 (
      .a_i   (slice_a),
      .b_i   (slice_b),
      .sum_o (partial)
   );

   assign acc_sum = acc_q + {{(ACC_W-PART_W){partial[PART_W-1]}}, partial};
   assign sat     = s_to_sm15_sat(acc_sum);

   always_comb begin
      state_d  = state_q;
      grp_d    = grp_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               // busy falls here on the edge after valid unless a new request is taken.
               busy_d = req;
               if (req) begin
                  state_d = ST_ACCUM;
                  grp_d   = '0;
                  acc_d   = '0;
               end
            end
            ST_ACCUM: begin
               acc_d = acc_sum;
               if (grp_q == GRP_W'(NGROUP-1)) begin
                  state_d  = ST_IDLE;
                  grp_d    = '0;
                  valid_d  = 1'b1;
                  result_d = sat.sm;
                  ovf_d    = sat.ovf;
               end else begin
                  grp_d = grp_q + GRP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         state_q  <= ST_IDLE;
         grp_q    <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grp_q    <= grp_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the operand copies are pure data, only read after an accept loads them, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         opa_q <= opr1;
         opb_q <= opr2;
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_float8_mac_responder.sv
// Self-checking bench for float8_mac_responder: directed vector table, random
// operands against an integer dot-product model, and handshake corner sequences.
module tb_float8_mac_responder;

   logic          clk;
   logic          iRst_n;
   logic          ena;
   logic          req;
   logic [1023:0] opr1;
   logic [1023:0] opr2;
   logic          busy;
   logic          valid;
   logic [14:0]   result;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   float8_mac_responder dut (
      .clk      (clk),
      .iRst_n   (iRst_n),
      .ena      (ena),
      .req      (req),
      .opr1     (opr1),
      .opr2     (opr2),
      .busy     (busy),
      .valid    (valid),
      .result   (result),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1023:0] a;
      logic [1023:0] b;
      logic [14:0]   exp_r;
      logic          exp_o;
      string         name;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sm_val(input logic [7:0] x);
      return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
   endfunction

   // Reference: exact integer dot product, then saturate to sign-magnitude Q0.14.
   function automatic logic [15:0] ref_mac(input logic [1023:0] a, input logic [1023:0] b);
      int   sum;
      int   mag;
      logic ovf;
      logic sgn;
      sum = 0;
      for (int i = 0; i < 128; i++) begin
         sum += sm_val(a[8*i +: 8]) * sm_val(b[8*i +: 8]);
      end
      mag = (sum < 0) ? -sum : sum;
      ovf = (mag > 16383);
      if (ovf) mag = 16383;
      sgn = (sum < 0) && (mag != 0);
      return {ovf, sgn, 14'(mag)};
   endfunction

   function automatic logic [1023:0] rand_vec(input int mode);
      logic [1023:0] v;
      logic [7:0]    lane;
      for (int i = 0; i < 128; i++) begin
         case (mode)
            0:       lane = 8'($urandom_range(0, 255));
            1:       lane = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))};
            default: lane = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
         endcase
         v[8*i +: 8] = lane;
      end
      return v;
   endfunction

   // Accept one request, then wait (bounded) for valid; checks busy, latency and the valid pulse width.
   task automatic run_op(input logic [1023:0] a, input logic [1023:0] b, input string name,
                         output logic [14:0] r, output logic o);
      int   n;
      logic seen;
      opr1 = a;
      opr2 = b;
      req  = 1'b1;
      tick();
      req  = 1'b0;
      check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (valid) seen = 1'b1;
      end
      check({name, "_latency"}, 32'(n), 32'd8);
      check({name, "_busy_at_valid"}, 32'(busy), 32'd1);
      r = result;
      o = overflow;
      tick();
      check({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
      check({name, "_busy_falls"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [1023:0] a, b, c, d, e, f;
      logic [15:0]   exp;
      logic [14:0]   r;
      logic          o;
      int            n;
      int            nvalid;
      logic          seen;

      // Directed vectors with hand-derived expectations.
      a = '0; b = '0; a[7:0] = 8'h40; b[7:0] = 8'h40;
      vecs[0] = '{{128{8'h7F}}, {128{8'h7F}}, 15'h3FFF, 1'b1, "all_7f"};
      vecs[1] = '{a, b, 15'h1000, 1'b0, "lane0_pos"};
      b[7:0] = 8'hC0;
      vecs[2] = '{a, b, 15'h5000, 1'b0, "lane0_neg"};
      a = '0; b = '0; a[47:40] = 8'h80; b[47:40] = 8'h7F;
      vecs[3] = '{a, b, 15'h0000, 1'b0, "neg_zero_operand"};
      a = '0; b = '0; a[7:0] = 8'h40; b[7:0] = 8'h40; a[1023:1016] = 8'h40; b[1023:1016] = 8'hC0;
      vecs[4] = '{a, b, 15'h0000, 1'b0, "cancel_to_zero"};
      vecs[5] = '{{128{8'h7F}}, {128{8'hFF}}, 15'h7FFF, 1'b1, "neg_saturate"};
      a = '0; b = '0; a[31:0] = {4{8'h01}}; b[31:0] = {4{8'h01}};
      vecs[6] = '{a, b, 15'h0004, 1'b0, "tiny_sum"};
      a = '0; b = '0; a[1023:1016] = 8'h7F; b[1023:1016] = 8'h7F;
      vecs[7] = '{a, b, 15'h3F01, 1'b0, "last_lane_max"};

      iRst_n = 1'b0;
      ena    = 1'b1;
      req    = 1'b0;
      opr1   = '0;
      opr2   = '0;
      repeat (2) tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      iRst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].name, r, o);
         check({vecs[i].name, "_result"}, 32'(r), 32'(vecs[i].exp_r));
         check({vecs[i].name, "_overflow"}, 32'(o), 32'(vecs[i].exp_o));
      end

      // Random operands against the integer model.
      for (int it = 0; it < 12; it++) begin
         a   = rand_vec(it % 3);
         b   = rand_vec((it + 1) % 3);
         exp = ref_mac(a, b);
         run_op(a, b, $sformatf("rand%0d", it), r, o);
         check($sformatf("rand%0d_result", it), 32'(r), 32'(exp[14:0]));
         check($sformatf("rand%0d_overflow", it), 32'(o), 32'(exp[15]));
      end

      // req pulses while busy are ignored; operand changes after accept do not matter.
      a = rand_vec(1);
      b = rand_vec(1);
      exp  = ref_mac(a, b);
      opr1 = a;
      opr2 = b;
      req  = 1'b1;
      tick();
      req  = 1'b0;
      opr1 = ~a;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         n++;
         req = (n == 3 || n == 6);
         tick();
         if (valid) seen = 1'b1;
         else check($sformatf("ignore_busy_c%0d", n), 32'(busy), 32'd1);
      end
      req = 1'b0;
      check("ignore_latency", 32'(n), 32'd8);
      check("ignore_result", 32'(result), 32'(exp[14:0]));
      check("ignore_overflow", 32'(overflow), 32'(exp[15]));
      tick();
      check("ignore_busy_falls", 32'(busy), 32'd0);

      // Back-to-back with req held: second valid exactly nine cycles after the first.
      c = rand_vec(2); d = rand_vec(1);
      e = rand_vec(1); f = rand_vec(2);
      opr1 = c;
      opr2 = d;
      req  = 1'b1;
      tick();
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (valid) seen = 1'b1;
      end
      check("b2b_first_latency", 32'(n), 32'd8);
      exp = ref_mac(c, d);
      check("b2b_first_result", 32'(result), 32'(exp[14:0]));
      opr1 = e;
      opr2 = f;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (valid) seen = 1'b1;
      end
      req = 1'b0;
      check("b2b_spacing", 32'(n), 32'd9);
      exp = ref_mac(e, f);
      check("b2b_second_result", 32'(result), 32'(exp[14:0]));
      check("b2b_second_overflow", 32'(overflow), 32'(exp[15]));
      tick();
      check("b2b_busy_falls", 32'(busy), 32'd0);

      // ena low for three cycles at grp=4 delays valid by three cycles.
      a = '0; b = '0;
      a[7:0] = 8'h55; b[7:0] = 8'h23;
      a[1023:1016] = 8'h91; b[1023:1016] = 8'h30;
      exp  = ref_mac(a, b);
      opr1 = a;
      opr2 = b;
      req  = 1'b1;
      tick();
      req  = 1'b0;
      repeat (4) tick();
      ena = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("ena_hold_valid%0d", k), 32'(valid), 32'd0);
         check($sformatf("ena_hold_busy%0d", k), 32'(busy), 32'd1);
      end
      ena  = 1'b1;
      n    = 7;
      seen = 1'b0;
      while (!seen && n < 30) begin
         tick();
         n++;
         if (valid) seen = 1'b1;
      end
      check("ena_latency", 32'(n), 32'd11);
      check("ena_result", 32'(result), 32'(exp[14:0]));
      check("ena_overflow", 32'(overflow), 32'(exp[15]));
      tick();

      // Reset at grp=4 aborts the operation with no valid.
      check("pre_reset_result_nonzero", 32'(result != 15'h0000), 32'd1);
      opr1 = {128{8'h7F}};
      opr2 = {128{8'h7F}};
      req  = 1'b1;
      tick();
      req  = 1'b0;
      repeat (4) tick();
      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      nvalid = 0;
      repeat (12) begin
         tick();
         if (valid) nvalid++;
      end
      check("abort_no_valid", 32'(nvalid), 32'd0);

      // Normal operation resumes after the abort.
      a = rand_vec(1);
      b = rand_vec(1);
      exp = ref_mac(a, b);
      run_op(a, b, "post_abort", r, o);
      check("post_abort_result", 32'(r), 32'(exp[14:0]));
      check("post_abort_overflow", 32'(o), 32'(exp[15]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
